// File: rtl/keepalive_pulser.sv
// Keepalive pulse-train generator: emits num_pulses pulses of high_len cycles separated by low_len-cycle gaps.
// All outputs are registered; pulse_out rises on the edge that accepts start. No backpressure: start is simply ignored while busy.
module keepalive_pulser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] high_len,
  input  logic [WIDTH-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SENT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] hi_m1_q, hi_m1_d;
  logic [WIDTH-1:0] lo_m1_q, lo_m1_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] hi_m1_in;
  logic [WIDTH-1:0] lo_m1_in;
  logic [CNT_W-1:0] sent_inc;

  // Phase lengths are kept as (length-1) so a zero length behaves as one cycle.
  always_comb begin
    hi_m1_in = (high_len == '0) ? '0 : (high_len - ONE_W);
    lo_m1_in = (low_len  == '0) ? '0 : (low_len  - ONE_W);
    sent_inc = (sent_q == SENT_MAX) ? sent_q : (sent_q + ONE_C);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_m1_d = hi_m1_q;
    lo_m1_d = lo_m1_q;
    num_d   = num_q;
    sent_d  = sent_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !abort) begin
          hi_m1_d = hi_m1_in;
          lo_m1_d = lo_m1_in;
          num_d   = num_pulses;
          sent_d  = '0;
          if (num_pulses != '0) begin
            state_d = HIGH;
            phase_d = hi_m1_in;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == '0) begin
          sent_d  = sent_inc;
          pulse_d = 1'b0;
          if (sent_inc == num_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            phase_d = lo_m1_q;
          end
        end else begin
          phase_d = phase_q - ONE_W;
        end
      end

      LOW: begin
        if (abort) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == '0) begin
          state_d = HIGH;
          phase_d = hi_m1_q;
          pulse_d = 1'b1;
        end else begin
          phase_d = phase_q - ONE_W;
        end
      end

      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      hi_m1_q <= '0;
      lo_m1_q <= '0;
      num_q   <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_m1_q <= hi_m1_d;
      lo_m1_q <= lo_m1_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_sent = sent_q;

endmodule

// File: tb/tb_keepalive_pulser.sv
// Directed bench for keepalive_pulser, with a small inactivity-timeout monitor fed by pulse_out.
module tb_keepalive_pulser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] high_len = 8'd0;
  logic [7:0] low_len = 8'd0;
  logic [7:0] num_pulses = 8'd0;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [7:0] pulses_sent;

  int vectors = 0;
  int errors  = 0;

  keepalive_pulser #(.WIDTH(8), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .high_len    (high_len),
    .low_len     (low_len),
    .num_pulses  (num_pulses),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  // Inactivity monitor: timeout is high when pulse_out has been low for MON_TGT full cycles after a pulse.
  localparam logic [3:0] MON_TGT = 4'd4;
  localparam logic [3:0] MON_SAT = 4'd5;
  logic [3:0] mon_cnt;
  logic       timeout;
  always_ff @(posedge clk) begin
    if (reset)                mon_cnt <= MON_SAT;
    else if (pulse_out)       mon_cnt <= 4'd0;
    else if (mon_cnt != MON_SAT) mon_cnt <= mon_cnt + 4'd1;
  end
  assign timeout = (mon_cnt == MON_TGT);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accepts a train at the next edge (cycle 0), then checks ncyc cycles against bit masks (bit i = cycle i).
  task automatic run_train(input string tag, input logic [7:0] hl, input logic [7:0] ll,
                           input logic [7:0] np, input int ncyc, input logic [31:0] exp_p,
                           input logic [31:0] exp_b, input logic [31:0] exp_d,
                           input logic hold, input logic [7:0] exp_sent);
    high_len   = hl;
    low_len    = ll;
    num_pulses = np;
    start      = 1'b1;
    tick();
    high_len   = 8'd7;
    low_len    = 8'd9;
    num_pulses = 8'd1;
    for (int i = 0; i < ncyc; i++) begin
      check($sformatf("%s pulse c%0d", tag, i), {31'd0, pulse_out}, {31'd0, exp_p[i]});
      check($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, {31'd0, exp_b[i]});
      check($sformatf("%s done c%0d", tag, i), {31'd0, done}, {31'd0, exp_d[i]});
      start = hold & exp_b[i];
      tick();
    end
    start = 1'b0;
    check($sformatf("%s sent", tag), {24'd0, pulses_sent}, {24'd0, exp_sent});
  endtask

  initial begin
    int done_seen;
    int first_to;
    int early_to;

    @(negedge clk);
    tick();
    check("reset pulse", {31'd0, pulse_out}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset sent", {24'd0, pulses_sent}, 32'd0);
    reset = 1'b0;

    // 2 high, 3 low, 2 pulses
    run_train("basic", 8'd2, 8'd3, 8'd2, 9, 32'h063, 32'h07F, 32'h080, 1'b0, 8'd2);
    run_train("zero_cnt", 8'd2, 8'd3, 8'd0, 3, 32'h0, 32'h0, 32'h1, 1'b0, 8'd0);
    run_train("zero_len", 8'd0, 8'd0, 8'd3, 7, 32'h15, 32'h1F, 32'h20, 1'b0, 8'd3);
    run_train("busy_start", 8'd2, 8'd3, 8'd2, 9, 32'h063, 32'h07F, 32'h080, 1'b1, 8'd2);

    // Abort during the first gap of a 4-pulse train
    high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort pre pulse", {31'd0, pulse_out}, 32'd0);
    check("abort pre busy", {31'd0, busy}, 32'd1);
    check("abort pre sent", {24'd0, pulses_sent}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort pulse", {31'd0, pulse_out}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort sent", {24'd0, pulses_sent}, 32'd1);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort no done", done_seen, 32'd0);
    run_train("after_abort", 8'd2, 8'd3, 8'd2, 9, 32'h063, 32'h07F, 32'h080, 1'b0, 8'd2);

    // abort and start together in IDLE: abort wins
    high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start busy", {31'd0, busy}, 32'd0);
    check("abort_start done", {31'd0, done}, 32'd0);

    // Reset in the second high phase, then start on the first edge after release
    high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst pre pulse", {31'd0, pulse_out}, 32'd1);
    check("rst pre sent", {24'd0, pulses_sent}, 32'd1);
    reset = 1'b1;
    tick();
    check("rst pulse", {31'd0, pulse_out}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst sent", {24'd0, pulses_sent}, 32'd0);
    reset = 1'b0; high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("rst restart busy", {31'd0, busy}, 32'd1);
    check("rst restart pulse", {31'd0, pulse_out}, 32'd1);
    tick();
    check("rst restart done", {31'd0, done}, 32'd1);

    // start held through a 1-pulse train: ignored while busy, accepted in the done cycle
    tick();
    high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd1; start = 1'b1;
    tick();
    check("dstart c0 busy", {31'd0, busy}, 32'd1);
    tick();
    check("dstart c1 done", {31'd0, done}, 32'd1);
    check("dstart c1 busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    check("dstart c2 busy", {31'd0, busy}, 32'd1);
    check("dstart c2 pulse", {31'd0, pulse_out}, 32'd1);
    check("dstart c2 done", {31'd0, done}, 32'd0);
    tick();
    check("dstart c3 done", {31'd0, done}, 32'd1);
    check("dstart c3 sent", {24'd0, pulses_sent}, 32'd1);

    // Loopback into the inactivity monitor: last pulse cycle is 11, timeout expected at 11+1+4
    for (int i = 0; i < 8; i++) tick();
    high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    first_to = -1;
    early_to = 0;
    for (int i = 0; i < 21; i++) begin
      if (timeout && first_to < 0) first_to = i;
      if (timeout && i <= 11) early_to++;
      tick();
    end
    check("loop early timeout", early_to, 32'd0);
    check("loop timeout cycle", first_to, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/keepalive_pulser.md
KEEPALIVE_PULSER -- requirements
Module: keepalive_pulser

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting the width of the phase-length inputs and the phase counter.
REQ-002 The module SHALL have parameter CNT_W, default 8, setting the width of the pulse-count input and the pulses_sent output.
REQ-003 The module SHALL have the port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have the port start, input, 1 bit: request to begin a pulse train; sampled only in IDLE.
REQ-006 The module SHALL have the port abort, input, 1 bit: synchronous cancel of the current train.
REQ-007 The module SHALL have the port high_len, input, WIDTH bits: pulse-high duration in cycles.
REQ-008 The module SHALL have the port low_len, input, WIDTH bits: gap duration in cycles between pulses.
REQ-009 The module SHALL have the port num_pulses, input, CNT_W bits: number of pulses in the train.
REQ-010 The module SHALL have the port pulse_out, output, 1 bit: registered activity pulse, intended to feed a downstream inactivity-timeout monitor.
REQ-011 The module SHALL have the port busy, output, 1 bit: high while a train is in progress.
REQ-012 The module SHALL have the port done, output, 1 bit: one-cycle completion strobe.
REQ-013 The module SHALL have the port pulses_sent, output, CNT_W bits: count of completed high phases in the current or most recent train.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, HIGH and LOW; all outputs SHALL be registered.
REQ-015 In IDLE, when start=1 and abort=0 at an edge, the module SHALL latch high_len, low_len and num_pulses, clear pulses_sent, and then proceed as follows.
REQ-016 On that edge, if the latched num_pulses is nonzero, the module SHALL enter HIGH and set pulse_out=1 and busy=1.
REQ-017 On that edge, if the latched num_pulses is 0, the module SHALL stay in IDLE with pulse_out=0 and busy=0, and assert done=1 for the next cycle.
REQ-018 Input changes after the accepting edge SHALL NOT affect the running train.
REQ-019 A latched high_len or low_len of 0 SHALL be treated as 1.
REQ-020 pulse_out SHALL remain 1 for exactly max(high_len,1) cycles per pulse, and 0 for exactly max(low_len,1) cycles between consecutive pulses.
REQ-021 At the edge ending each high phase, pulses_sent SHALL increment by 1.
REQ-022 If pulses_sent then equals num_pulses, the module SHALL go to IDLE with pulse_out=0, busy=0 and done=1 for one cycle.
REQ-023 Otherwise, at the edge ending each high phase, the module SHALL go to LOW.
REQ-024 From LOW, after the gap completes, the module SHALL return to HIGH.
REQ-025 The pulse period SHALL be max(high_len,1)+max(low_len,1) cycles, and no LOW phase SHALL follow the final pulse.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 start in the done cycle SHALL be accepted, since the module is already in IDLE.
REQ-028 abort=1 in HIGH or LOW SHALL, at the next edge, force IDLE with pulse_out=0, busy=0 and done=0, and SHALL hold pulses_sent.
REQ-029 If abort and start are asserted in the same IDLE cycle, abort SHALL win and start SHALL be ignored.
REQ-030 The phase counter SHALL be WIDTH bits and SHALL never wrap, since it reloads at each phase boundary.
REQ-031 pulses_sent SHALL saturate at its maximum value (never wrap), since num_pulses bounds it.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE, pulse_out=0, busy=0, done=0 and pulses_sent=0, overriding start and abort.
REQ-033 Reset mid-train SHALL terminate the train without asserting done.
REQ-034 After reset is released, the module SHALL accept start on the first subsequent edge.

Verification
REQ-035 Basic train: high_len=2, low_len=3, num_pulses=2, start sampled at edge E0 -> pulse_out high in cycles E0..E0+1, low E0+2..E0+4, high E0+5..E0+6; done=1 in cycle E0+7; busy high in cycles E0..E0+6; pulses_sent=2.
REQ-036 Zero count: num_pulses=0, start -> done=1 for one cycle, pulse_out and busy never high, pulses_sent=0.
REQ-037 Zero lengths: high_len=0, low_len=0, num_pulses=3 -> pulse_out pattern 1,0,1,0,1 then done, for 6 cycles total from start acceptance.
REQ-038 Abort: abort after 1 complete pulse of a 4-pulse train, during LOW -> next cycle pulse_out=0, busy=0, done never asserted, pulses_sent=1; a new start is then accepted normally.
REQ-039 Reset mid-HIGH: all outputs 0 the next cycle, no done; start during busy is ignored, with the pulse pattern unchanged.
REQ-040 Loopback: pulse_out driven into the team's inactivity-timeout monitor with target below the period -> the monitor's timeout indication never fires during the train, and fires target+1 cycles after the final pulse.
